// File: rtl/multimode_ff_pkg.sv
// Shared definitions for the multimode flip-flop register: mode encodings,
// forbidden-SR policy codes and the S=R=1 resolution helper.
package multimode_ff_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_D    = 3'b001,
    MODE_T    = 3'b010,
    MODE_JK   = 3'b011,
    MODE_SR   = 3'b100,
    MODE_SHL  = 3'b101,
    MODE_SHR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  localparam int SRP_HOLD   = 0;
  localparam int SRP_SET    = 1;
  localparam int SRP_RESET  = 2;
  localparam int SRP_TOGGLE = 3;

  // Resolves S=R=1; unknown policy codes fall back to hold so q never goes X.
  function automatic logic sr_forbidden_nxt(input int policy, input logic q);
    logic r;
    case (policy)
      SRP_SET:    r = 1'b1;
      SRP_RESET:  r = 1'b0;
      SRP_TOGGLE: r = ~q;
      default:    r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mm_ff_cell.sv
// Combinational next-state function for one bit of multimode_ff_reg.
// Flops, enable gating, shift wiring and error tracking live in the top level.
module mm_ff_cell
  import multimode_ff_pkg::*;
#(
  parameter int SR_POLICY = SRP_HOLD
) (
  input  logic [2:0] mode,
  input  logic       q,
  input  logic       a,
  input  logic       b,
  input  logic       shift_src,
  input  logic       rst_bit,
  output logic       nxt
);

  always_comb begin
    nxt = q;
    case (mode)
      MODE_HOLD: nxt = q;
      MODE_D:    nxt = a;
      MODE_T:    nxt = q ^ a;
      MODE_JK: begin
        case ({a, b})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      MODE_SR: begin
        case ({a, b})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11:   nxt = sr_forbidden_nxt(SR_POLICY, q);
          default: nxt = q;
        endcase
      end
      MODE_SHL, MODE_SHR: nxt = shift_src;
      MODE_CLR:           nxt = rst_bit;
      default:            nxt = q;
    endcase
  end

endmodule

// File: rtl/multimode_ff_reg.sv
// WIDTH-bit register whose bits act as D/T/JK/SR flip-flops or a shift register,
// with sticky reporting of forbidden S=R=1 inputs.
module multimode_ff_reg
  import multimode_ff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SR_POLICY = SRP_HOLD
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ser_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             ser_out,
  output logic             sr_err,
  output logic [WIDTH-1:0] err_bits
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] shift_src;
  logic [WIDTH-1:0] viol_bits;
  logic             viol;
  logic             sr_err_q, sr_err_d;
  logic [WIDTH-1:0] err_bits_q, err_bits_d;

  // Shift neighbours are wired per bit so WIDTH=1 degenerates to loading ser_in.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic shl_src, shr_src;

    if (gi == 0) begin : g_shl_edge
      assign shl_src = ser_in;
    end else begin : g_shl_mid
      assign shl_src = q_q[gi-1];
    end

    if (gi == WIDTH - 1) begin : g_shr_edge
      assign shr_src = ser_in;
    end else begin : g_shr_mid
      assign shr_src = q_q[gi+1];
    end

    assign shift_src[gi] = (mode == MODE_SHR) ? shr_src : shl_src;

    mm_ff_cell #(
      .SR_POLICY(SR_POLICY)
    ) u_cell (
      .mode     (mode),
      .q        (q_q[gi]),
      .a        (a[gi]),
      .b        (b[gi]),
      .shift_src(shift_src[gi]),
      .rst_bit  (RESET_VAL[gi]),
      .nxt      (nxt[gi])
    );
  end

  assign viol_bits = a & b;
  assign viol      = en && (mode == MODE_SR) && (|viol_bits);

  always_comb begin
    q_d        = en ? nxt : q_q;
    sr_err_d   = sr_err_q;
    err_bits_d = err_bits_q;
    // A violation on the clearing edge wins, but only its own bits survive.
    if (viol) begin
      sr_err_d   = 1'b1;
      err_bits_d = err_clr ? viol_bits : (err_bits_q | viol_bits);
    end else if (err_clr) begin
      sr_err_d   = 1'b0;
      err_bits_d = '0;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      q_q        <= RESET_VAL;
      sr_err_q   <= 1'b0;
      err_bits_q <= '0;
    end else begin
      q_q        <= q_d;
      sr_err_q   <= sr_err_d;
      err_bits_q <= err_bits_d;
    end
  end

  always_comb begin
    ser_out = 1'b0;
    if (mode == MODE_SHL) ser_out = q_q[WIDTH-1];
    else if (mode == MODE_SHR) ser_out = q_q[0];
  end

  assign q        = q_q;
  assign qn       = ~q_q;
  assign sr_err   = sr_err_q;
  assign err_bits = err_bits_q;

endmodule

// File: doc/multimode_ff_reg.md
Name: multimode_ff_reg

Overview:
- Parametrised successor to the single-bit SR/D flip-flop cells: a WIDTH-bit register in which every bit behaves as a D, T, JK or SR flip-flop, selected per cycle by a shared mode input.
- Also provides shift-left, shift-right and synchronous-clear modes.
- Handles the SR forbidden input (S=R=1) deterministically via a parameter and reports it with sticky error flags instead of driving X.
- Used as the general-purpose state/flag register in control paths.

Parameters:
- WIDTH, 8, number of register bits (1..32).
- RESET_VAL, 0, value loaded into q on reset and in CLR mode (WIDTH bits).
- SR_POLICY, 0, action on S=R=1: 0 hold, 1 set, 2 reset, 3 toggle.

Ports:
- clk  in  1  rising-edge clock.
- res  in  1  asynchronous reset, active-low.
- en  in  1  update enable; 0 means q holds regardless of mode.
- mode  in  3  operation select (encoding below).
- a  in  WIDTH  D data / T mask / J / S operand.
- b  in  WIDTH  K / R operand; ignored in other modes.
- ser_in  in  1  serial input for shift modes.
- err_clr  in  1  clears sr_err and err_bits.
- q  out  WIDTH  register state.
- qn  out  WIDTH  ~q, combinational.
- ser_out  out  1  bit shifted out: q[WIDTH-1] in SHL, q[0] in SHR, else 0 (combinational from mode and q).
- sr_err  out  1  sticky: an S=R=1 condition occurred.
- err_bits  out  WIDTH  sticky OR of offending bit positions.

Behaviour:
- Reset: res=0 forces q=RESET_VAL, sr_err=0 and err_bits=0 immediately, independent of clk. Release is synchronous to the next rising clk; the first update happens on the first edge with res=1.
- All updates occur on the rising edge of clk when en=1. With en=0, q holds and the error logic is not updated, except that err_clr still acts.
- Mode encoding, applied per bit i on an en=1 edge:
  - 000 HOLD: q unchanged.
  - 001 D: q[i]<=a[i].
  - 010 T: q[i]<=q[i]^a[i].
  - 011 JK: 00 hold, 01 reset, 10 set, 11 toggle (J=a[i], K=b[i]).
  - 100 SR: 00 hold, 01 reset, 10 set, 11 per SR_POLICY (S=a[i], R=b[i]).
  - 101 SHL: q<={q[WIDTH-2:0],ser_in}.
  - 110 SHR: q<={ser_in,q[WIDTH-1:1]}.
  - 111 CLR: q<=RESET_VAL.
- WIDTH=1: SHL and SHR both load ser_in.
- The output never carries X for any combination of known inputs.
- Error detection: violation = en & (mode==SR) & |(a&b).
  - On a violating edge: sr_err<=1 and err_bits<=err_bits|(a&b).
  - err_clr=1 on an edge clears both.
  - If a violation and err_clr occur on the same edge, the violation wins: sr_err=1 and err_bits = exactly the new a&b (old bits are cleared).
  - a&b in non-SR modes never flags.
- Latency: q is valid one clk after the inputs are sampled. Errors are visible in the same cycle as the q update.
- Reset mid-operation, including mid-shift, discards the state with no recovery.

Decomposition:
- Package multimode_ff_pkg holds:
  - mode constants: MODE_HOLD, MODE_D, MODE_T, MODE_JK, MODE_SR, MODE_SHL, MODE_SHR, MODE_CLR;
  - SR_POLICY constants: SRP_HOLD, SRP_SET, SRP_RESET, SRP_TOGGLE.
- Sub-module mm_ff_cell: a purely combinational 1-bit next-state function with inputs mode, q, a, b, shift_src and rst_bit, and output nxt.
  - It is instantiated WIDTH times in a generate loop.
  - The top level owns the flops, shift wiring and error logic.

Test Plan:
- Reset and D mode: res=0 with RESET_VAL=8'hA5 gives q=A5 asynchronously, mid-cycle. After release, D with a=3C gives q=3C next edge; with en=0 and a=FF, q stays 3C.
- T and JK: q=0F, T with a=FF gives F0. JK with a=F0, b=0F gives F0 (set hi, reset lo). JK with a=FF, b=FF then toggles to 0F.
- SR policies: q=55, SR with a=0F, b=03 makes bits 1:0 policy-dependent and bits 3:2 set. Expected q: policy 0 gives 5D, 1 gives 5F, 2 gives 5C, 3 gives 5E. In all cases sr_err=1 and err_bits=03.
- Sticky errors: a second violation with a&b=80 gives err_bits=83. err_clr alone gives 0. err_clr together with a violation a&b=10 gives sr_err=1 and err_bits=10.
- Shifts: q=81, SHL with ser_in=1 gives ser_out=1 before the edge and q=03 after. SHR with ser_in=0 gives q=01. Eight SHR edges with ser_in=1 give FF.
- CLR and reset mid-shift: CLR gives A5. Asserting res low between edges during a shift sequence makes q=A5 immediately. After release, q does not change until the first edge with en=1.
